// File: rtl/sdram_bist.sv
// Traffic generator and readback checker for the sdram_core request port.
// Runs sequential or xorshift patterns and records mismatches and timeouts.
module sdram_bist #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [31:0] ADDR_RANGE_MASK = 32'h00FF_FFFF,
  parameter logic [31:0] SEED = 32'hACE1_1234,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  wr,
  output logic                  rd,
  input  logic                  rdy,
  input  logic                  wvalid,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] read_data
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Generator registers hold the value already advanced once from the seed.
  localparam logic [31:0] SEED_D = xorshift(SEED);
  localparam logic [31:0] SEED_A = xorshift(SEED ^ 32'h5A5A_5A5A);

  function automatic logic [ADDR_WIDTH-1:0] gen_addr(input logic [IW-1:0] idx,
                                                      input logic [31:0] ra,
                                                      input logic rnd);
    return rnd ? BASE_ADDR + ADDR_WIDTH'(ra & ADDR_RANGE_MASK & ~32'(BYTES - 1))
               : BASE_ADDR + ADDR_WIDTH'(idx) * ADDR_WIDTH'(BYTES);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] gen_data(input logic [IW-1:0] idx,
                                                      input logic [31:0] rdv,
                                                      input logic rnd);
    return rnd ? rdv[DATA_WIDTH-1:0] : DATA_WIDTH'(idx);
  endfunction

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [IW-1:0]   index;
  logic [31:0]     rand_d;
  logic [31:0]     rand_a;
  logic [TW-1:0]   tcnt;

  logic            rnd_addr_c;
  logic            rnd_data_c;
  logic [IW-1:0]   idx_next_c;
  logic [31:0]     rd_adv_c;
  logic [31:0]     ra_adv_c;
  logic [DATA_WIDTH-1:0] exp_data_c;
  logic            mismatch_c;
  logic            active_c;
  logic            progress_c;
  logic            tmo_c;

  assign rnd_addr_c = (mode_q == 2'd2);
  assign rnd_data_c = (mode_q == 2'd1) || (mode_q == 2'd2);
  assign idx_next_c = index + IW'(1);
  assign rd_adv_c   = xorshift(rand_d);
  assign ra_adv_c   = xorshift(rand_a);
  assign exp_data_c = gen_data(index, rand_d, rnd_data_c);
  assign mismatch_c = (read_data != exp_data_c);
  assign active_c   = (state == WR_REQ) || (state == WR_WAIT) ||
                      (state == RD_REQ) || (state == RD_WAIT);
  assign progress_c = ((state == WR_REQ) && rdy) || ((state == WR_WAIT) && wvalid) ||
                      ((state == RD_REQ) && rdy) || ((state == RD_WAIT) && rvalid);
  assign tmo_c      = active_c && !progress_c && (tcnt >= TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode_q         <= '0;
      index          <= '0;
      rand_d         <= '0;
      rand_a         <= '0;
      tcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      addr           <= '0;
      write_data     <= '0;
      wr             <= 1'b0;
      rd             <= 1'b0;
    end else if (tmo_c) begin
      state      <= DONE;
      wr         <= 1'b0;
      rd         <= 1'b0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b1;
      timeout    <= 1'b1;
      pass       <= 1'b0;
    end else begin
      if (active_c) tcnt <= tcnt + TW'(1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            mode_q         <= mode;
            index          <= '0;
            rand_d         <= SEED_D;
            rand_a         <= SEED_A;
            tcnt           <= '0;
            addr           <= gen_addr(IW'(0), SEED_A, mode == 2'd2);
            write_data     <= gen_data(IW'(0), SEED_D, (mode == 2'd1) || (mode == 2'd2));
            wr             <= 1'b1;
            state          <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (rdy) begin
            wr         <= 1'b0;
            write_data <= '0;
            state      <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (wvalid) begin
            tcnt <= '0;
            if (rnd_addr_c) begin
              // Interleaved mode reads back the same word straight away.
              rd    <= 1'b1;
              state <= RD_REQ;
            end else if (index == LAST_IDX) begin
              index  <= '0;
              rand_d <= SEED_D;
              addr   <= gen_addr(IW'(0), rand_a, 1'b0);
              rd     <= 1'b1;
              state  <= RD_REQ;
            end else begin
              index      <= idx_next_c;
              rand_d     <= rd_adv_c;
              addr       <= gen_addr(idx_next_c, rand_a, 1'b0);
              write_data <= gen_data(idx_next_c, rd_adv_c, rnd_data_c);
              wr         <= 1'b1;
              state      <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (rdy) begin
            rd    <= 1'b0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rvalid) begin
            if (mismatch_c) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (err_count == '0) begin
                first_err_addr <= addr;
                first_err_data <= read_data;
              end
            end
            if (index == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch_c;
              state <= DONE;
            end else begin
              index  <= idx_next_c;
              rand_d <= rd_adv_c;
              tcnt   <= '0;
              if (rnd_addr_c) begin
                rand_a     <= ra_adv_c;
                addr       <= gen_addr(idx_next_c, ra_adv_c, 1'b1);
                write_data <= gen_data(idx_next_c, rd_adv_c, rnd_data_c);
                wr         <= 1'b1;
                state      <= WR_REQ;
              end else begin
                addr  <= gen_addr(idx_next_c, rand_a, 1'b0);
                rd    <= 1'b1;
                state <= RD_REQ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
